// File: rtl/ps2_host_tx.sv
// rtl/ps2_host_tx.sv - PS/2 host-to-device command byte transmitter
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 5000,
  parameter int SETUP_CYCLES   = 50,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic [7:0] tx_data_i,
  input  logic       tx_start_i,
  input  logic       ps2_clock_in_i,
  input  logic       ps2_data_in_i,
  output logic       ps2_clock_oe_o,
  output logic       ps2_data_oe_o,
  output logic       tx_busy_o,
  output logic       tx_done_o,
  output logic       tx_error_o
);

  localparam int PHASE_MAX = (INHIBIT_CYCLES > SETUP_CYCLES) ? INHIBIT_CYCLES : SETUP_CYCLES;
  localparam int PW        = $clog2(PHASE_MAX + 1);
  localparam int TW        = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [PW-1:0] INHIBIT_LAST = PW'(INHIBIT_CYCLES - 1);
  localparam logic [PW-1:0] SETUP_LAST   = PW'(SETUP_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INHIBIT,
    S_START,
    S_SEND,
    S_WAIT_RELEASE
  } state_e;

  state_e        state_q, state_d;

  logic          clk_meta_q, clk_sync_q, clk_prev_q;
  logic          dat_meta_q, dat_sync_q;

  logic [PW-1:0] phase_q, phase_d;
  logic [TW-1:0] timeout_q, timeout_d;
  logic [3:0]    edge_q, edge_d;
  logic [7:0]    byte_q, byte_d;
  logic          parity_q, parity_d;
  logic          data_oe_q, data_oe_d;
  logic          done_q, done_d;
  logic          error_q, error_d;

  logic          fall;
  logic          timeout_hit;
  logic          lines_idle;
  logic [3:0]    edge_next;

  // A device clock falling edge is a 1 -> 0 step of the synchronised clock
  assign fall        = clk_prev_q & ~clk_sync_q;
  assign lines_idle  = clk_sync_q & dat_sync_q;
  assign edge_next   = edge_q + 4'd1;
  // The counter's next value would reach the limit; a falling edge always wins
  assign timeout_hit = ~fall & (timeout_q == TIMEOUT_LAST);

  // Two-flop synchronisers, idle-line value 1, plus a delayed clock copy for edge detection
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      clk_meta_q <= 1'b1;
      clk_sync_q <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_meta_q <= 1'b1;
      dat_sync_q <= 1'b1;
    end else begin
      clk_meta_q <= ps2_clock_in_i;
      clk_sync_q <= clk_meta_q;
      clk_prev_q <= clk_sync_q;
      dat_meta_q <= ps2_data_in_i;
      dat_sync_q <= dat_meta_q;
    end
  end

  // FSM state register
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state: fixed-length inhibit/setup phases, then edge-driven frame
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (tx_start_i) state_d = S_INHIBIT;
      end
      S_INHIBIT: begin
        if (phase_q == INHIBIT_LAST) state_d = S_START;
      end
      S_START: begin
        if (phase_q == SETUP_LAST) state_d = S_SEND;
      end
      S_SEND: begin
        if (fall && (edge_next == 4'd11)) begin
          state_d = dat_sync_q ? S_IDLE : S_WAIT_RELEASE;
        end else if (timeout_hit) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT_RELEASE: begin
        if (lines_idle || timeout_hit) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Datapath next-state: counters, latched byte, bit being driven, result pulses
  always_comb begin
    phase_d   = '0;
    timeout_d = timeout_q;
    edge_d    = edge_q;
    byte_d    = byte_q;
    parity_d  = parity_q;
    data_oe_d = data_oe_q;
    done_d    = 1'b0;
    error_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (tx_start_i) begin
          byte_d   = tx_data_i;
          parity_d = ~^tx_data_i;
        end
      end
      S_INHIBIT: begin
        if (state_d == S_INHIBIT) phase_d = phase_q + 1'b1;
      end
      S_START: begin
        if (state_d == S_START) begin
          phase_d = phase_q + 1'b1;
        end else begin
          // Start bit stays on the line while the clock is released
          data_oe_d = 1'b1;
          edge_d    = 4'd0;
          timeout_d = '0;
        end
      end
      S_SEND: begin
        if (fall) begin
          edge_d    = edge_next;
          timeout_d = '0;
          case (edge_next)
            4'd9:    data_oe_d = ~parity_q;
            4'd10:   data_oe_d = 1'b0;
            4'd11:   data_oe_d = 1'b0;
            default: data_oe_d = ~byte_q[edge_q[2:0]];
          endcase
          if ((edge_next == 4'd11) && dat_sync_q) error_d = 1'b1;
        end else if (timeout_hit) begin
          error_d = 1'b1;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      S_WAIT_RELEASE: begin
        if (lines_idle) begin
          done_d = 1'b1;
        end else if (fall) begin
          timeout_d = '0;
        end else if (timeout_hit) begin
          error_d = 1'b1;
        end else begin
          timeout_d = timeout_q + 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Datapath registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      phase_q   <= '0;
      timeout_q <= '0;
      edge_q    <= 4'd0;
      byte_q    <= 8'd0;
      parity_q  <= 1'b0;
      data_oe_q <= 1'b0;
      done_q    <= 1'b0;
      error_q   <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      timeout_q <= timeout_d;
      edge_q    <= edge_d;
      byte_q    <= byte_d;
      parity_q  <= parity_d;
      data_oe_q <= data_oe_d;
      done_q    <= done_d;
      error_q   <= error_d;
    end
  end

  // FSM outputs: line drives decoded from state so reset releases them at once
  always_comb begin
    ps2_clock_oe_o = 1'b0;
    ps2_data_oe_o  = 1'b0;
    tx_busy_o      = (state_q != S_IDLE);
    tx_done_o      = done_q;
    tx_error_o     = error_q;
    case (state_q)
      S_INHIBIT: begin
        ps2_clock_oe_o = 1'b1;
      end
      S_START: begin
        ps2_clock_oe_o = 1'b1;
        ps2_data_oe_o  = 1'b1;
      end
      S_SEND: begin
        ps2_data_oe_o = data_oe_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// tb/tb_ps2_host_tx.sv - self-checking bench for ps2_host_tx with a PS/2 device model
module tb_ps2_host_tx;

  localparam int INH = 20;
  localparam int SET = 4;
  localparam int TMO = 200;
  localparam int HALF = 20;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_start = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error;
  logic       clk_line, data_line;

  // open-drain wired-AND of host and device on each pin
  assign clk_line  = dev_clk & ~ps2_clock_oe;
  assign data_line = dev_data & ~ps2_data_oe;

  ps2_host_tx #(
    .INHIBIT_CYCLES(INH),
    .SETUP_CYCLES  (SET),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock_i       (clk),
    .reset_i       (rst),
    .tx_data_i     (tx_data),
    .tx_start_i    (tx_start),
    .ps2_clock_in_i(clk_line),
    .ps2_data_in_i (data_line),
    .ps2_clock_oe_o(ps2_clock_oe),
    .ps2_data_oe_o (ps2_data_oe),
    .tx_busy_o     (tx_busy),
    .tx_done_o     (tx_done),
    .tx_error_o    (tx_error)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int last_err_cyc = -1;

  typedef struct {
    logic [7:0] data;
    bit         ack;
    int         stop_after;
    int         exp_done;
    int         exp_err;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // advance one clock and observe the result pulses
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (tx_done) done_cnt++;
    if (tx_error) begin
      err_cnt++;
      last_err_cyc = cyc;
    end
    if (tx_done && tx_error) both_cnt++;
  endtask

  // one full host transfer against the device model; frame is read at each rising clock
  task automatic run_xfer(input logic [7:0] d, input bit ack, input int stop_after,
                          input int exp_done, input int exp_err,
                          input bit poke_inhibit, input bit chain);
    logic [9:0] frame;
    logic       exp_par;
    int         n, d0, e0, fall_cyc;
    frame    = '0;
    fall_cyc = 0;
    exp_par  = ($countones(d) % 2 == 0);
    d0 = done_cnt;
    e0 = err_cnt;
    tx_start = 1'b1;
    tx_data  = d;
    tick();
    tx_start = 1'b0;
    tx_data  = 8'($urandom);
    chk("accept", 32'({ps2_clock_oe, ps2_data_oe, tx_busy}), 32'(3'b101));
    n = 0;
    while (ps2_clock_oe && !ps2_data_oe && n < 100) begin
      n++;
      if (poke_inhibit && n == 5) begin
        tx_start = 1'b1;
        tx_data  = ~d;
      end else begin
        tx_start = 1'b0;
      end
      tick();
    end
    tx_start = 1'b0;
    chk("inhibit_len", 32'(n), 32'(INH));
    n = 0;
    while (ps2_clock_oe && ps2_data_oe && n < 100) begin
      n++;
      tick();
    end
    chk("setup_len", 32'(n), 32'(SET));
    chk("start_bit", 32'({ps2_clock_oe, ps2_data_oe}), 32'(2'b01));
    repeat (5) tick();
    for (int k = 1; k <= 11; k++) begin
      if (stop_after != 0 && k > stop_after) break;
      if (k == 11) dev_data = ack ? 1'b0 : 1'b1;
      dev_clk  = 1'b0;
      fall_cyc = cyc;
      repeat (HALF) tick();
      dev_clk = 1'b1;
      if (k <= 10) frame[k-1] = data_line;
      repeat (HALF) tick();
      dev_data = 1'b1;
    end
    n = 0;
    if (stop_after != 0) begin
      while (err_cnt == e0 && n < 400) begin
        tick();
        n++;
      end
      // 2 synchroniser flops + edge register, then the timeout period
      chk("timeout_at", 32'(last_err_cyc - fall_cyc), 32'(TMO + 3));
    end else begin
      while (done_cnt == d0 && err_cnt == e0 && n < 400) begin
        tick();
        n++;
      end
    end
    chk("released", 32'({ps2_clock_oe, ps2_data_oe, tx_busy}), 32'(0));
    chk("done_pulses", 32'(done_cnt - d0), 32'(exp_done));
    chk("err_pulses", 32'(err_cnt - e0), 32'(exp_err));
    if (stop_after == 0) begin
      chk("data_bits", 32'(frame[7:0]), 32'(d));
      chk("parity_bit", 32'(frame[8]), 32'(exp_par));
      chk("stop_bit", 32'(frame[9]), 32'(1));
    end
    if (chain) begin
      chk("chain_in_done_cycle", 32'(tx_done), 32'(1));
      return;
    end
    repeat (3) tick();
    chk("idle_after", 32'({tx_busy, ps2_clock_oe, ps2_data_oe}), 32'(0));
    chk("single_pulse", 32'(done_cnt - d0 + err_cnt - e0), 32'(exp_done + exp_err));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, d0, e0;
    bit ack;
    vecs[0] = '{8'hED, 1'b1, 0, 1, 0};
    vecs[1] = '{8'h01, 1'b1, 0, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 0, 1, 0};
    vecs[3] = '{8'h00, 1'b1, 0, 1, 0};
    vecs[4] = '{8'hA5, 1'b0, 0, 0, 1};
    vecs[5] = '{8'h3C, 1'b1, 5, 0, 1};

    // reset state
    repeat (3) tick();
    chk("reset_outputs", 32'({ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}), 32'(0));
    rst = 1'b0;
    tick();
    chk("idle_outputs", 32'({ps2_clock_oe, ps2_data_oe, tx_busy, tx_done, tx_error}), 32'(0));

    for (int i = 0; i < 6; i++) begin
      run_xfer(vecs[i].data, vecs[i].ack, vecs[i].stop_after,
               vecs[i].exp_done, vecs[i].exp_err, 1'b0, 1'b0);
    end

    // start pulse during INHIBIT is ignored
    run_xfer(8'h5A, 1'b1, 0, 1, 0, 1'b1, 1'b0);

    // start in the tx_done cycle is accepted straight away
    run_xfer(8'h96, 1'b1, 0, 1, 0, 1'b0, 1'b1);
    run_xfer(8'h2B, 1'b1, 0, 1, 0, 1'b0, 1'b0);

    // reset mid-transfer after edge 6
    tx_start = 1'b1;
    tx_data  = 8'hC3;
    tick();
    tx_start = 1'b0;
    n = 0;
    while (ps2_clock_oe && n < 100) begin
      tick();
      n++;
    end
    repeat (5) tick();
    for (int k = 1; k <= 6; k++) begin
      dev_clk = 1'b0;
      if (k < 6) begin
        repeat (HALF) tick();
        dev_clk = 1'b1;
        repeat (HALF) tick();
      end
    end
    repeat (5) tick();
    chk("busy_before_reset", 32'(tx_busy), 32'(1));
    #2;
    rst = 1'b1;
    #1;
    chk("reset_async", 32'({ps2_clock_oe, ps2_data_oe, tx_busy}), 32'(0));
    dev_clk = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    d0 = done_cnt;
    e0 = err_cnt;
    repeat (50) tick();
    chk("no_pulse_after_reset", 32'(done_cnt - d0 + err_cnt - e0), 32'(0));
    chk("idle_after_reset", 32'({ps2_clock_oe, ps2_data_oe, tx_busy}), 32'(0));
    run_xfer(8'hC3, 1'b1, 0, 1, 0, 1'b0, 1'b0);

    // randomised bytes and ACK/NACK against the frame model
    for (int i = 0; i < 12; i++) begin
      ack = ($urandom_range(0, 3) != 0);
      run_xfer(8'($urandom), ack, 0, ack ? 1 : 0, ack ? 0 : 1, 1'b0, 1'b0);
    end

    chk("never_both", 32'(both_cnt), 32'(0));
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
